// File: rtl/bcd_counter_scan.sv
// N-digit BCD up/down counter with free-running tick and scan dividers,
// driving a time-multiplexed 7-segment bank with optional leading-zero blanking.
module bcd_counter_scan #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 50_000_000,
    parameter int SCAN_DIV = 50_000,
    parameter bit ACT_LOW  = 1'b1,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  wrap,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [TW-1:0]     TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0]     SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]     IDX_LAST  = IW'(DIGITS - 1);
    localparam logic [6:0]        SEG_OFF   = {7{ACT_LOW}};
    localparam logic [DIGITS-1:0] AN_OFF    = {DIGITS{ACT_LOW}};

    logic [TW-1:0]       r_tcnt;
    logic [SW-1:0]       r_scnt;
    logic [IW-1:0]       r_idx;
    logic [4*DIGITS-1:0] r_bcd;
    logic                r_wrap;
    logic [6:0]          r_seg;
    logic [DIGITS-1:0]   r_an;

    logic                w_tick;
    logic                w_scan_adv;
    logic [4*DIGITS-1:0] w_bcd_inc;
    logic [4*DIGITS-1:0] w_bcd_dec;
    logic                w_all9;
    logic                w_all0;
    logic [4*DIGITS-1:0] w_load_sat;
    logic [DIGITS-1:0]   w_blank;
    logic [DIGITS-1:0]   w_an_hot;
    logic [3:0]          w_digit;
    logic                w_digit_blank;
    logic [6:0]          w_seg_hi;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    assign w_tick     = (r_tcnt == TICK_LAST);
    assign w_scan_adv = (r_scnt == SCAN_LAST);

    // Ripple carry/borrow through the digits; a carry surviving the top digit
    // means every digit was 9 (or 0 for the borrow), i.e. the count wraps.
    always_comb begin
        logic       v_carry;
        logic       v_borrow;
        logic [3:0] v_d;
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_bcd_inc  = '0;
        w_bcd_dec  = '0;
        w_load_sat = '0;
        v_carry    = 1'b1;
        v_borrow   = 1'b1;
        v_d        = '0;
        for (int k = 0; k < DIGITS; k++) begin
            v_d = r_bcd[4*k +: 4];
            if (v_carry && v_d == 4'd9) begin
                w_bcd_inc[4*k +: 4] = 4'd0;
            end else if (v_carry) begin
                w_bcd_inc[4*k +: 4] = v_d + 4'd1;
                v_carry = 1'b0;
            end else begin
                w_bcd_inc[4*k +: 4] = v_d;
            end
            if (v_borrow && v_d == 4'd0) begin
                w_bcd_dec[4*k +: 4] = 4'd9;
            end else if (v_borrow) begin
                w_bcd_dec[4*k +: 4] = v_d - 4'd1;
                v_borrow = 1'b0;
            end else begin
                w_bcd_dec[4*k +: 4] = v_d;
            end
            w_load_sat[4*k +: 4] = (load_val[4*k +: 4] > 4'd9) ? 4'd9 : load_val[4*k +: 4];
        end
        w_all9 = v_carry;
        w_all0 = v_borrow;
    end

    // Display path: blanking mask, selected digit and its one-hot anode.
    always_comb begin
        logic v_zero_above;
        w_blank       = '0;
        w_an_hot      = '0;
        w_digit       = '0;
        w_digit_blank = 1'b0;
        v_zero_above  = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            v_zero_above = v_zero_above && (r_bcd[4*k +: 4] == 4'd0);
            w_blank[k]   = BLANK_LZ && (k > 0) && v_zero_above;
        end
        for (int k = 0; k < DIGITS; k++) begin
            if (r_idx == IW'(k)) begin
                w_an_hot[k]   = 1'b1;
                w_digit       = r_bcd[4*k +: 4];
                w_digit_blank = w_blank[k];
            end
        end
        w_seg_hi = w_digit_blank ? 7'h00 : seg7(w_digit);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tcnt <= '0;
            r_scnt <= '0;
            r_idx  <= '0;
            r_bcd  <= '0;
            r_wrap <= 1'b0;
            r_seg  <= SEG_OFF;
            r_an   <= AN_OFF;
        end else begin
            r_tcnt <= w_tick ? '0 : r_tcnt + 1'b1;
            r_scnt <= w_scan_adv ? '0 : r_scnt + 1'b1;
            if (w_scan_adv) begin
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end

            r_wrap <= 1'b0;
            if (load) begin
                r_bcd <= w_load_sat;
            end else if (w_tick && en) begin
                if (up) begin
                    r_bcd  <= w_bcd_inc;
                    r_wrap <= w_all9;
                end else begin
                    r_bcd  <= w_bcd_dec;
                    r_wrap <= w_all0;
                end
            end

            r_seg <= w_seg_hi ^ SEG_OFF;
            r_an  <= w_an_hot ^ AN_OFF;
        end
    end

    assign bcd  = r_bcd;
    assign wrap = r_wrap;
    assign seg  = r_seg;
    assign an   = r_an;

endmodule
